fp16_fma_issuer: RTL
====================

// Module: fp16_fma_issuer
// PURPOSE
//  Initiator/collector for the FP16FMA datapath, which has a fixed latency and no stall input.
//  Accepts (a,b,c) operand triples on a valid/ready slave port and issues them to the FMA.
//  Captures FMA results into a result FIFO and drains them on a valid/ready master port.
//  Credit control guarantees that no FMA result is ever dropped under downstream backpressure.
// PARAMETERS
//  LATENCY  4  cycles from fma_in_valid to fma_out_valid; must match the paired FP16FMA
//  DEPTH    8  result FIFO entries, power of two, >= LATENCY+2 for one-per-cycle throughput
// PORTS
//  clk            in   1   single clock; all logic is on the rising edge
//  rst            in   1   synchronous, active-high reset
//  s_valid        in   1   operand triple valid
//  s_ready        out  1   issuer can accept a triple this cycle
//  s_a/s_b/s_c    in   16  FP16 operands; the FMA computes a*b+c
//  fma_in_valid   out  1   registered issue strobe to FP16FMA in_valid
//  fma_a/b/c      out  16  registered operands to FP16FMA a/b/c
//  fma_out_valid  in   1   FP16FMA out_valid
//  fma_out        in   16  FP16FMA out
//  m_valid        out  1   result available
//  m_ready        in   1   downstream accepts the result
//  m_data         out  16  FIFO head (FP16 result), in issue order
//  busy           out  1   inflight != 0 or FIFO non-empty
//  err            out  1   sticky: FIFO overflow, or a result arrived with inflight == 0
// BEHAVIOUR
//  - Reset: s_ready=0, fma_in_valid=0, fma_a/b/c=0, m_valid=0, m_data=0, busy=0, err=0.
//    Reset also clears inflight, count and the pointers.
//  - Drain window: after rst deasserts, a counter runs for LATENCY+1 cycles (FP16FMA valid
//    regs are unreset). During this window:
//      * s_ready=0;
//      * fma_out_valid is ignored (no push, no err).
//    The same applies when rst is asserted mid-operation: in-flight results are discarded.
//  - s_ready = !drain && (inflight + count < DEPTH). Computed from registers only; it does
//    not depend on m_ready or s_valid.
//  - Issue: when s_valid && s_ready, then next cycle:
//      * fma_in_valid=1;
//      * fma_a/b/c = operands;
//      * inflight increments at the same edge.
//    Otherwise fma_in_valid=0 and the operands hold their values.
//  - Latency: handshake -> FIFO write is 1+LATENCY cycles. Write -> m_valid is 1 cycle
//    (registered FIFO).
//  - Push: fma_out_valid (outside the drain window) writes fma_out at wr_ptr and decrements
//    inflight. If inflight==0, set err and do not push. If FIFO is full, set err and drop
//    the result.
//  - Simultaneous issue and return: inflight is unchanged.
//  - Pop: m_valid && m_ready advances rd_ptr.
//  - Simultaneous push and pop: count is unchanged, which is legal even when the FIFO is full.
//  - m_valid = (count != 0); m_data = mem[rd_ptr]. m_data holds while m_valid && !m_ready.
//  - Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
//    inflight saturates by construction, so it cannot exceed DEPTH.
//  - FSM states:
//      * DRAIN (after reset) -> IDLE when the counter expires;
//      * IDLE -> RUN on the first handshake;
//      * RUN -> IDLE when !busy.
//    state affects only s_ready (gated in DRAIN) and busy.
//  - err clears only on rst.
// CONFIGURATION
//  - FMA_ISSUER_PERF_EN defined: adds output ports perf_issued[31:0] (count of issued
//    triples) and perf_stall[31:0] (count of cycles with s_valid && !s_ready && !drain).
//    Both reset to 0 and wrap at 2^32.
//  - Undefined: the ports and the counters are absent. All other behaviour is identical.
// TESTING (bench pairs this block with FP16FMA, LATENCY=4, DEPTH=8)
//  1. Single op, a=0x3C00 b=0x4000 c=0x3800, m_ready=1:
//     m_data=0x4100 (2.5) with m_valid high 6 cycles after the handshake; busy returns to 0.
//  2. Stream of 32 triples, s_valid=1 and m_ready=1 continuously:
//     s_ready stays 1 after drain; 32 results in order; zero bubbles; err=0.
//  3. m_ready=0 while streaming: at most 8 issued, then s_ready=0; FIFO fills to 8, nothing
//     lost, err=0. Release m_ready: all results drain in order and s_ready reasserts.
//  4. Assert rst for 1 cycle with 3 ops in flight:
//     outputs zero; no results appear; s_ready=0 for 5 cycles, then 1; err=0.
//  5. Force fma_out_valid=1 with inflight=0 (after drain): err=1 and stays 1 until rst.
//  6. With FMA_ISSUER_PERF_EN, repeat scenario 3 for 20 cycles of stall:
//     perf_issued=8, perf_stall=12.

Source files
------------

// File: rtl/fp16_fma_issuer.sv
// Operand issuer and result collector for a fixed-latency FP16 FMA, with credit-based FIFO.
// Optional perf counters under FMA_ISSUER_PERF_EN.
module fp16_fma_issuer #(
   parameter int LATENCY = 4,
   parameter int DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [15:0] s_a,
   input  logic [15:0] s_b,
   input  logic [15:0] s_c,
   output logic        fma_in_valid,
   output logic [15:0] fma_a,
   output logic [15:0] fma_b,
   output logic [15:0] fma_c,
   input  logic        fma_out_valid,
   input  logic [15:0] fma_out,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [15:0] m_data,
   output logic        busy,
   output logic        err
`ifdef FMA_ISSUER_PERF_EN
   ,
   output logic [31:0] perf_issued,
   output logic [31:0] perf_stall
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(LATENCY + 1);

   localparam logic [1:0] ST_DRAIN = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] drain_cnt_q, drain_cnt_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic          fiv_q, fiv_d;
   logic [15:0]   a_q, a_d, b_q, b_d, c_q, c_d;
   logic          err_q, err_d;
   logic [15:0]   mem [DEPTH];

   logic          drain, issue, ret, ret_ok, push, pop, full;
   logic [CW:0]   occ;

   assign drain   = (state_q == ST_DRAIN);
   assign occ     = {1'b0, inflight_q} + {1'b0, count_q};
   assign s_ready = !drain && (occ < (CW+1)'(DEPTH));
   assign issue   = s_valid && s_ready;
   assign m_valid = (count_q != '0);
   assign pop     = m_valid && m_ready;
   assign full    = (count_q == CW'(DEPTH));
   // Results emerging while draining are stale pipeline contents.
   assign ret     = fma_out_valid && !drain;
   assign ret_ok  = ret && (inflight_q != '0);
   assign push    = ret_ok && (!full || pop);
   assign busy    = (inflight_q != '0) || (count_q != '0);
   assign m_data  = m_valid ? mem[rd_ptr_q] : 16'h0000;

   assign fma_in_valid = fiv_q;
   assign fma_a        = a_q;
   assign fma_b        = b_q;
   assign fma_c        = c_q;
   assign err          = err_q;

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      unique case (state_q)
         ST_DRAIN: begin
            if (drain_cnt_q == '0) state_d = ST_IDLE;
            else drain_cnt_d = drain_cnt_q - DW'(1);
         end
         ST_IDLE: if (issue) state_d = ST_RUN;
         ST_RUN:  if (!busy) state_d = ST_IDLE;
         default: state_d = ST_DRAIN;
      endcase
   end

   always_comb begin
      inflight_d = inflight_q;
      if (issue && !ret_ok) inflight_d = inflight_q + CW'(1);
      else if (!issue && ret_ok) inflight_d = inflight_q - CW'(1);
      count_d = count_q;
      if (push && !pop) count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      fiv_d    = issue;
      a_d      = issue ? s_a : a_q;
      b_d      = issue ? s_b : b_q;
      c_d      = issue ? s_c : c_q;
      err_d    = err_q | (ret && (inflight_q == '0)) | (ret_ok && !push);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_DRAIN;
         drain_cnt_q <= DW'(LATENCY);
         inflight_q  <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fiv_q       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         inflight_q  <= inflight_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fiv_q       <= fiv_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         err_q       <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= fma_out;
   end

`ifdef FMA_ISSUER_PERF_EN
   logic [31:0] perf_issued_q, perf_issued_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_issued_d = perf_issued_q + 32'(issue);
      perf_stall_d  = perf_stall_q + 32'(s_valid && !s_ready && !drain);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issued_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_issued_q <= perf_issued_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_issued = perf_issued_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule
